// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit five-stage CPU.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_LD  = 4'h8,
    OP_ST  = 4'h9,
    OP_BEQ = 4'hA,
    OP_JMP = 4'hB,
    OP_HLT = 4'hF
  } opcode_e;

  localparam logic [3:0] HLT_OP_DEFAULT = OP_HLT;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_incr;
  } fetch_entry_t;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous prefetch queue with flush; head is read straight from storage.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o,
  output logic         empty_o
);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_s, push_en_s, pop_en_s;

  assign empty_o   = (count_q == '0);
  assign full_s    = (count_q == DEPTH_C);
  assign pop_en_s  = pop_i && !empty_o;
  assign push_en_s = push_i && (!full_s || pop_en_s);
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Occupancy update
  always_comb begin
    count_d = count_q;
    case ({push_en_s, pop_en_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count; flush only rewinds the pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_en_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  fetch_fifo_chk u_chk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push_i),
    .pop_i  (pop_en_s),
    .flush_i(flush_i),
    .full_i (full_s)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Overflow checker for the fetch prefetch queue.
module fetch_fifo_chk (
  input logic clk_i,
  input logic rst_i,
  input logic push_i,
  input logic pop_i,
  input logic flush_i,
  input logic full_i
);

  ovf_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_i && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-based memory issue, prefetch queue, redirect and halt.
// Define FETCH_PERF_EN to add the stall_cnt / flush_cnt performance counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               DEPTH    = 2,
  parameter logic [ADDR_W-1:0] PC_INCR  = 16'h0001,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [3:0]        HLT_OP   = HLT_OP_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  im_addr,
  output logic               im_rd_en,
  input  logic [INSTR_W-1:0] im_instr,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc_incr,
  output logic               hlt_fetched
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              inflight_q, inflight_d;
  logic              hlt_q, hlt_d;

  logic [CW-1:0]     count_s, occupancy_s;
  logic              empty_s, issue_s, push_s, pop_s, hlt_set_s;
  fetch_entry_t      push_data_s, head_s;

  // Queue entries plus the outstanding read must stay within the queue size
  assign occupancy_s = count_s + CW'(inflight_q);
  assign issue_s     = !rst && !hlt_q && !redirect && (occupancy_s < DEPTH_C);
  // A late response is dropped after a redirect or once HLT is queued
  assign push_s      = inflight_q && !redirect && !hlt_q;
  assign pop_s       = out_valid && out_ready;
  assign hlt_set_s   = push_s && (opcode_of(im_instr) == HLT_OP);

  assign push_data_s.instr   = im_instr;
  assign push_data_s.pc_incr = tag_q + PC_INCR;

  assign im_addr     = pc_q;
  assign im_rd_en    = issue_s;
  assign out_valid   = !empty_s;
  assign out_instr   = head_s.instr;
  assign out_pc_incr = head_s.pc_incr;
  assign hlt_fetched = hlt_q;

  // Next PC, in-flight tag and halt state; redirect overrides everything
  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    hlt_d      = hlt_q;
    if (redirect) begin
      pc_d  = redirect_pc;
      hlt_d = 1'b0;
    end else begin
      if (issue_s) begin
        pc_d       = pc_q + PC_INCR;
        tag_d      = pc_q;
        inflight_d = 1'b1;
      end else begin
        inflight_d = 1'b0;
      end
      if (hlt_set_s) begin
        hlt_d = 1'b1;
      end else begin
        hlt_d = hlt_q;
      end
    end
  end

  // Fetch state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      tag_q      <= 16'h0000;
      inflight_q <= 1'b0;
      hlt_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      hlt_q      <= hlt_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (push_s),
    .pop_i  (pop_s),
    .flush_i(redirect),
    .data_i (push_data_s),
    .head_o (head_s),
    .count_o(count_s),
    .empty_o(empty_s)
  );

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating stall and flush counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if (out_ready && !out_valid && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'h0001;
      end
      if (redirect && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'h0001;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle vector table, directed corner sequences, random stream vs model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [15:0] im_instr;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc_incr;
  logic        hlt_fetched;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .im_addr    (im_addr),
    .im_rd_en   (im_rd_en),
    .im_instr   (im_instr),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc_incr(out_pc_incr),
    .hlt_fetched(hlt_fetched)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  // synchronous instruction memory: data one cycle after the read request
  always @(posedge clk) begin
    if (im_rd_en) im_instr <= mem[im_addr];
  end

  typedef struct {
    logic        rst, rdy, redir;
    logic [15:0] rpc;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_vld;
    logic        chk_data;
    logic [15:0] e_instr, e_pinc;
  } vec_t;

  vec_t tv [12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] acc_i [0:7];
    logic [15:0] acc_p [0:7];
    int          acc_n;
    int          issues;
    int          post_hlt;
    logic        hlt_seen;
    logic [15:0] ea, ei;
    int          outstanding;
    int          accepted_total;
    logic        prev_redir;

    for (int i = 0; i < 65536; i++) mem[i] = i[15:0];
    mem[16'hFFFF] = 16'h0ABC;

    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; out_ready = 1'b0;

    // rst rdy redir rpc | rd_en addr valid chk instr pc_incr
    tv[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b1, 16'h0000, 16'h0000};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 1'b1, 16'h0000, 16'h0001};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 1'b1, 16'h0001, 16'h0002};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tv[7]  = '{1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0004, 1'b1, 1'b1, 16'h0002, 16'h0003};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tv[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0042, 1'b1, 1'b1, 16'h0040, 16'h0041};
    tv[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 1'b1, 16'h0041, 16'h0042};

    // reset, straight-line fetch, redirect with a read in flight
    for (int r = 0; r < 12; r++) begin
      rst = tv[r].rst; out_ready = tv[r].rdy;
      redirect = tv[r].redir; redirect_pc = tv[r].rpc;
      @(negedge clk);
      check($sformatf("tv%0d_rd_en", r), {15'd0, im_rd_en}, {15'd0, tv[r].e_rd});
      check($sformatf("tv%0d_addr", r), im_addr, tv[r].e_addr);
      check($sformatf("tv%0d_valid", r), {15'd0, out_valid}, {15'd0, tv[r].e_vld});
      check($sformatf("tv%0d_hlt", r), {15'd0, hlt_fetched}, 16'h0000);
      if (tv[r].chk_data) begin
        check($sformatf("tv%0d_instr", r), out_instr, tv[r].e_instr);
        check($sformatf("tv%0d_pc_incr", r), out_pc_incr, tv[r].e_pinc);
      end
      tick();
    end

    // backpressure: only DEPTH reads may be outstanding
    redirect = 1'b1; redirect_pc = 16'h0100; out_ready = 1'b0;
    tick();
    redirect = 1'b0;
    issues = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (im_rd_en) issues++;
      if (c == 9) begin
        check("bp_rd_en_low", {15'd0, im_rd_en}, 16'h0000);
        check("bp_valid", {15'd0, out_valid}, 16'h0001);
        check("bp_head", out_instr, 16'h0100);
      end
      tick();
    end
    check("bp_issues", issues[15:0], 16'h0002);
    out_ready = 1'b1;
    acc_n = 0;
    for (int c = 0; c < 12 && acc_n < 3; c++) begin
      @(negedge clk);
      if (out_valid) begin acc_i[acc_n] = out_instr; acc_p[acc_n] = out_pc_incr; acc_n++; end
      tick();
    end
    check("bp_drain_n", acc_n[15:0], 16'h0003);
    for (int k = 0; k < 3 && k < acc_n; k++) begin
      check($sformatf("bp_drain%0d_instr", k), acc_i[k], 16'h0100 + k[15:0]);
      check($sformatf("bp_drain%0d_pc_incr", k), acc_p[k], 16'h0101 + k[15:0]);
    end

    // asynchronous reset mid-stream
    mem[3] = 16'hF000;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", {15'd0, out_valid}, 16'h0000);
    check("rst_mid_addr", im_addr, 16'h0000);
    check("rst_mid_rd_en", {15'd0, im_rd_en}, 16'h0000);
    tick();
    rst = 1'b0;

    // HLT at address 3: drain 0..3 then stop
    acc_n = 0; post_hlt = 0; hlt_seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (hlt_seen && im_rd_en) post_hlt++;
      if (out_valid && out_ready && acc_n < 8) begin
        acc_i[acc_n] = out_instr; acc_p[acc_n] = out_pc_incr; acc_n++;
      end
      hlt_seen = hlt_seen | hlt_fetched;
      tick();
    end
    @(negedge clk);
    check("hlt_flag", {15'd0, hlt_fetched}, 16'h0001);
    check("hlt_count", acc_n[15:0], 16'h0004);
    check("hlt_no_issue", post_hlt[15:0], 16'h0000);
    check("hlt_valid_low", {15'd0, out_valid}, 16'h0000);
    if (acc_n == 4) begin
      check("hlt_e0", acc_i[0], 16'h0000);
      check("hlt_e1", acc_i[1], 16'h0001);
      check("hlt_e2", acc_i[2], 16'h0002);
      check("hlt_e3", acc_i[3], 16'hF000);
      check("hlt_e3_pc_incr", acc_p[3], 16'h0004);
    end
    tick();

    // redirect after halt
    redirect = 1'b1; redirect_pc = 16'h0010;
    @(negedge clk);
    check("rh_no_issue", {15'd0, im_rd_en}, 16'h0000);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("rh_hlt_clear", {15'd0, hlt_fetched}, 16'h0000);
    check("rh_rd_en", {15'd0, im_rd_en}, 16'h0001);
    check("rh_addr", im_addr, 16'h0010);
    tick();

    // PC wrap at FFFF
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("wrap_addr0", im_addr, 16'hFFFF);
    check("wrap_rd0", {15'd0, im_rd_en}, 16'h0001);
    tick();
    @(negedge clk);
    check("wrap_addr1", im_addr, 16'h0000);
    check("wrap_rd1", {15'd0, im_rd_en}, 16'h0001);
    tick();
    @(negedge clk);
    check("wrap_valid", {15'd0, out_valid}, 16'h0001);
    check("wrap_instr", out_instr, 16'h0ABC);
    check("wrap_pc_incr", out_pc_incr, 16'h0000);
    tick();

    // random stream against an in-order program model
    mem[3] = 16'h0003;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ea = 16'h0000; ei = 16'h0000; outstanding = 0; accepted_total = 0; prev_redir = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom_range(0, 16'h0EFF));
      @(negedge clk);
      if (prev_redir) check("rnd_flush_valid", {15'd0, out_valid}, 16'h0000);
      if (redirect) check("rnd_redir_no_issue", {15'd0, im_rd_en}, 16'h0000);
      if (im_rd_en) begin
        check("rnd_issue_addr", im_addr, ei);
        check("rnd_credit", {15'd0, (outstanding < 2)}, 16'h0001);
        ei = ei + 16'h0001;
        outstanding++;
      end
      if (out_valid && out_ready) begin
        check("rnd_instr", out_instr, mem[ea]);
        check("rnd_pc_incr", out_pc_incr, ea + 16'h0001);
        ea = ea + 16'h0001;
        outstanding--;
        accepted_total++;
      end
      if (redirect) begin
        ea = redirect_pc; ei = redirect_pc; outstanding = 0;
      end
      prev_redir = redirect;
      tick();
    end
    redirect = 1'b0;
    check("rnd_progress", {15'd0, (accepted_total > 300)}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that feeds the IF/ID pipeline register of the 5-stage 16-bit CPU.
- Owns the program counter and issues word reads to the synchronous instruction memory.
- Buffers returned instructions in a small prefetch queue and hands {instr, pc_incr} to decode over a valid/ready handshake.
- Accepts branch redirects from EX/MEM, which flush the queue, and stops fetching after a HLT opcode.

Parameters:
- DEPTH, 2, prefetch queue entries; power of two, at least 2.
- PC_INCR, 1, PC increment per instruction (word-addressed memory).
- RESET_PC, 16'h0000, PC value after reset.
- HLT_OP, 4'hF, opcode in instr[15:12] that stops fetching.

Ports:
- clk  in  1  global clock, rising edge
- rst  in  1  asynchronous, active-high reset
- im_addr  out  16  instruction memory address
- im_rd_en  out  1  instruction memory read request
- im_instr  in  16  read data, valid exactly one cycle after im_rd_en
- redirect  in  1  branch taken; single-cycle pulse
- redirect_pc  in  16  branch target
- out_valid  out  1  queue head valid to decode
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  16  head instruction
- out_pc_incr  out  16  address of head instruction + PC_INCR
- hlt_fetched  out  1  HLT has been enqueued; fetch is stopped

Behaviour:
- Reset (asynchronous, active-high):
  - pc = RESET_PC; queue empty; no read in flight.
  - im_rd_en = 0, out_valid = 0, hlt_fetched = 0.
  - out_instr and out_pc_incr = 0.
- Issue rule: im_rd_en = !stopped && !redirect && (count + inflight < DEPTH). Here inflight is 0 or 1 and stopped = hlt_fetched.
  - im_addr = pc, combinational from the PC register.
  - On issue: pc <= pc + PC_INCR (16-bit wrap, FFFF -> 0000 when PC_INCR = 1). The issued address is recorded in the inflight tag.
- Response: the cycle after an issue, {im_instr, tag + PC_INCR} is written to the queue tail unless the inflight entry has been squashed.
  - Credit accounting guarantees no overflow; overflow is an assertion failure.
- Dequeue: when out_valid && out_ready, the head pops. Enqueue and dequeue in the same cycle leave count unchanged. A full queue with a simultaneous pop accepts the response.
- Outputs out_instr and out_pc_incr come straight from the queue head with no extra latency.
- Minimum latency: issue at cycle N, response at N+1, out_valid at N+2 (registered queue).
- HLT: when an enqueued instruction has instr[15:12] == HLT_OP, hlt_fetched <= 1 and further issue is blocked.
  - Entries already in the queue still drain.
  - A response that arrives after the HLT is enqueued is squashed.
- Redirect has highest priority and takes effect in the same cycle:
  - queue flushed (count = 0; out_valid = 0 from the next cycle);
  - any in-flight response squashed;
  - pc <= redirect_pc; hlt_fetched <= 0;
  - no issue in the redirect cycle; fetch resumes at redirect_pc the next cycle.
- A dequeue coinciding with a redirect is still taken by decode. Upstream squashes it via the pipeline flush.
- Back-to-back redirects: each one overrides the previous; the last target wins.
- Reset mid-operation: all state is cleared immediately; a pending memory response is ignored.
- Queue pointers are log2(DEPTH) bits with wrap; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports stall_cnt[15:0] and flush_cnt[15:0], both reset to 0 and saturating at FFFF.
  - stall_cnt increments each cycle with out_ready && !out_valid.
  - flush_cnt increments on each redirect.
- Undefined: the ports and counters are absent and function is unchanged.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants, including HLT_OP_DEFAULT;
  - INSTR_W = 16 and ADDR_W = 16;
  - a packed struct fetch_entry_t {instr, pc_incr}.
- One sub-module, fetch_fifo: a parameterised DEPTH-entry synchronous FIFO with push, pop, flush, count, head data and an async active-high reset.
- Issue, tag and halt logic stay in fetch_unit.

Test Plan:
- Straight-line fetch: memory holds instr = addr, out_ready tied 1 -> im_addr 0,1,2,... every cycle; out_instr 0000,0001,... with out_pc_incr 0001,0002,..., first out_valid two cycles after reset release.
- Backpressure: out_ready = 0 for 10 cycles -> exactly DEPTH (2) entries queued, im_rd_en low after the credit is exhausted; on release, 0000,0001 arrive in order with none lost.
- Redirect with a read in flight: redirect to 0x0040 at cycle 5 -> the squashed response is dropped, next out_instr = mem[0x0040] with out_pc_incr = 0x0041.
- HLT: mem[3] = F000 -> hlt_fetched = 1 after it is enqueued, im_rd_en stays 0, entries 0..3 drain, no further out_valid.
- Redirect after halt: redirect to 0x0010 -> hlt_fetched clears and fetch resumes at 0x0010.
- Wrap and reset: start pc at FFFF -> next im_addr is 0000; assert rst mid-stream -> out_valid = 0 and im_addr = RESET_PC in the same cycle.
